// File: rtl/ip_sniffer_pkg.sv
// Shared types and the byte-alignment helper for the IP word packer.
// IP_PACKER_GAP_EN adds the GAP state used for inter-frame zero words.
package ip_sniffer_pkg;

  typedef logic [31:0] ip_addr_t;
  typedef logic [1:0]  byte_off_t;

`ifdef IP_PACKER_GAP_EN
  typedef enum logic [1:0] {IDLE, W0, W1, GAP} pack_state_t;
`else
  typedef enum logic [1:0] {IDLE, W0, W1} pack_state_t;
`endif

  localparam int unsigned REQ_W = 34;

  // Returns {word0, word1}; word1 is zero for offset 0.
  function automatic logic [63:0] ip_shift_words(input ip_addr_t ip, input byte_off_t off);
    logic [5:0]  sh;
    logic [31:0] w0;
    logic [31:0] w1;
    sh = {1'b0, off, 3'b000};
    w0 = ip >> sh;
    w1 = (off == 2'd0) ? '0 : ip << (6'd32 - sh);
    return {w0, w1};
  endfunction

endpackage

// File: rtl/ip_req_fifo.sv
// Synchronous request FIFO, DEPTH x WIDTH, async active-low reset, sync flush.
module ip_req_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/ip_word_packer.sv
// Places queued IPv4 addresses at a byte offset as two stream words.
// Define IP_PACKER_GAP_EN to append GAP_WORDS zero cycles after each frame.
module ip_word_packer
  import ip_sniffer_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned GAP_WORDS = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_ip,
  input  logic [1:0]  req_offset,
  output logic [31:0] data_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_done,
  output logic        busy
);

  pack_state_t      state, state_nx;
  logic [31:0]      data_nx, word1_q, word1_nx;
  logic             valid_nx, done_nx, pop, to_next;
  logic [REQ_W-1:0] head;
  logic [63:0]      head_words;
  logic             fifo_full, fifo_empty;

`ifdef IP_PACKER_GAP_EN
  localparam int unsigned GW = $clog2(GAP_WORDS + 1);
  logic [GW-1:0] gap_cnt, gap_cnt_nx;
`endif

  ip_req_fifo #(.DEPTH(DEPTH), .WIDTH(REQ_W)) u_fifo (
    .clk    (clk),
    .n_rst  (n_rst),
    .flush  (clear),
    .push   (req_valid && req_ready),
    .pop    (pop),
    .wr_data({req_ip, req_offset}),
    .rd_data(head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign head_words = ip_shift_words(head[33:2], head[1:0]);
  assign req_ready  = !fifo_full && !clear;
  assign busy       = (state != IDLE) || !fifo_empty;

  // to_next marks a free slot: launch the FIFO head or fall back to IDLE.
  always_comb begin
    state_nx = state;
    data_nx  = data_out;
    valid_nx = out_valid;
    word1_nx = word1_q;
    done_nx  = 1'b0;
    pop      = 1'b0;
    to_next  = 1'b0;
`ifdef IP_PACKER_GAP_EN
    gap_cnt_nx = gap_cnt;
`endif
    case (state)
      IDLE: to_next = 1'b1;
      W0: if (out_ready) begin
        state_nx = W1;
        data_nx  = word1_q;
      end
      W1: if (out_ready) begin
        done_nx = 1'b1;
`ifdef IP_PACKER_GAP_EN
        state_nx   = GAP;
        gap_cnt_nx = GW'(GAP_WORDS - 1);
        data_nx    = '0;
        valid_nx   = 1'b0;
`else
        to_next = 1'b1;
`endif
      end
`ifdef IP_PACKER_GAP_EN
      GAP: begin
        if (gap_cnt == '0) to_next = 1'b1;
        else gap_cnt_nx = gap_cnt - 1'b1;
      end
`endif
      default: state_nx = IDLE;
    endcase

    if (to_next) begin
      if (!fifo_empty) begin
        pop      = 1'b1;
        state_nx = W0;
        data_nx  = head_words[63:32];
        word1_nx = head_words[31:0];
        valid_nx = 1'b1;
      end else begin
        state_nx = IDLE;
        data_nx  = '0;
        valid_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      data_out   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      word1_q    <= '0;
`ifdef IP_PACKER_GAP_EN
      gap_cnt    <= '0;
`endif
    end else if (clear) begin
      state      <= IDLE;
      data_out   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      word1_q    <= '0;
`ifdef IP_PACKER_GAP_EN
      gap_cnt    <= '0;
`endif
    end else begin
      state      <= state_nx;
      data_out   <= data_nx;
      out_valid  <= valid_nx;
      frame_done <= done_nx;
      word1_q    <= word1_nx;
`ifdef IP_PACKER_GAP_EN
      gap_cnt    <= gap_cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_ip_word_packer.sv
// Randomised and directed bench for ip_word_packer against a queue-based model.
`timescale 1ns/1ps
module tb_ip_word_packer;

  localparam int unsigned DEPTH     = 2;
  localparam int unsigned GAP_WORDS = 2;
`ifdef IP_PACKER_GAP_EN
  localparam int GAPW = GAP_WORDS;
`else
  localparam int GAPW = 0;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        clear = 1'b0;
  logic        req_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] req_ip = '0;
  logic [1:0]  req_offset = '0;
  logic        req_ready, out_valid, frame_done, busy;
  logic [31:0] data_out;

  ip_word_packer #(.DEPTH(DEPTH), .GAP_WORDS(GAP_WORDS)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clear),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ip    (req_ip),
    .req_offset(req_offset),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: pending address pairs, the frame on the wire, and the gap left.
  logic [63:0] pend_q[$];
  logic [63:0] cur = '0;
  logic        active = 1'b0;
  int          phase = 0;
  int          gap = 0;
  logic        fd_exp = 1'b0;
  logic [31:0] acc_q[$];
  int          acc_t[$];
  int          cyc = 0;
  int          fd_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] expect_words(input logic [31:0] ip, input logic [1:0] off);
    logic [63:0] wide;
    wide = {ip, 32'h0};
    return wide >> (int'(off) * 8);
  endfunction

  task automatic model_reset();
    pend_q.delete();
    active = 1'b0;
    phase  = 0;
    gap    = 0;
    fd_exp = 1'b0;
  endtask

  // Inputs are already driven; check outputs, advance the model across one edge.
  task automatic tick();
    logic [31:0] exp_word;
    logic        exp_ready;
    logic        push;
    int          sz;
    #1;
    exp_ready = (pend_q.size() < DEPTH) && !clear;
    exp_word  = !active ? 32'h0 : ((phase == 0) ? cur[63:32] : cur[31:0]);
    chk("req_ready",  32'(req_ready),  32'(exp_ready));
    chk("out_valid",  32'(out_valid),  32'(active));
    chk("data_out",   data_out,        exp_word);
    chk("busy",       32'(busy),       32'(active || pend_q.size() > 0 || gap > 0));
    chk("frame_done", 32'(frame_done), 32'(fd_exp));
    if (frame_done) fd_seen++;
    if (clear) begin
      model_reset();
    end else begin
      push   = req_valid && exp_ready;
      sz     = pend_q.size();
      fd_exp = 1'b0;
      if (gap > 0) gap--;
      if (active && out_ready) begin
        acc_q.push_back(data_out);
        acc_t.push_back(cyc);
        if (phase == 0) phase = 1;
        else begin
          active = 1'b0;
          fd_exp = 1'b1;
          gap    = GAPW;
        end
      end
      if (!active && gap == 0 && sz > 0) begin
        cur    = pend_q.pop_front();
        active = 1'b1;
        phase  = 0;
      end
      if (push) pend_q.push_back(expect_words(req_ip, req_offset));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [31:0] ip, input logic [1:0] off);
    req_valid  = 1'b1;
    req_ip     = ip;
    req_offset = off;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    req_valid = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    while ((active || pend_q.size() > 0 || gap > 0 || fd_exp) && n < max) begin
      tick();
      n++;
    end
    if (active || pend_q.size() > 0 || gap > 0) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  logic [31:0] tbl [8] = '{32'hC0A80101, 32'h00000000, 32'h00C0A801, 32'h01000000,
                           32'h0000C0A8, 32'h01010000, 32'h000000C0, 32'hA8010100};

  initial begin
    int acc_cnt;
    int fd0;
    int bad;

    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    tick();
    tick();

    // Offsets 0..3 of 192.168.1.1
    for (int o = 0; o < 4; o++) begin
      acc_q.delete();
      send(32'hC0A80101, 2'(o));
      drain(20);
      chk("off_words", 32'(acc_q.size()), 32'd2);
      if (acc_q.size() == 2) begin
        chk("off_w0", acc_q[0], tbl[2*o]);
        chk("off_w1", acc_q[1], tbl[2*o+1]);
      end
    end

    // Backpressure holds word0
    acc_q.delete();
    out_ready = 1'b0;
    send(32'hC0A80101, 2'd1);
    tick();
    repeat (3) begin
      chk("hold_word",  data_out, 32'h00C0A801);
      chk("hold_valid", 32'(out_valid), 32'd1);
      tick();
    end
    drain(20);
    chk("bp_words", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() == 2) begin
      chk("bp_w0", acc_q[0], 32'h00C0A801);
      chk("bp_w1", acc_q[1], 32'h01000000);
    end

    // Fill the FIFO while downstream stalls
    acc_q.delete();
    out_ready = 1'b0;
    acc_cnt   = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      req_valid  = 1'b1;
      req_ip     = 32'h0A000001 + 32'(i);
      req_offset = 2'(i);
      #1;
      if (req_ready) acc_cnt++;
      tick();
    end
    req_valid = 1'b0;
    chk("fill_accepted", 32'(acc_cnt), 32'(DEPTH + 1));
    drain(60);
    chk("fill_words", 32'(acc_q.size()), 32'(2 * (DEPTH + 1)));

    // Clear during word1 of FFFFFFFF/off2 with another entry queued
    acc_q.delete();
    out_ready = 1'b1;
    send(32'hFFFFFFFF, 2'd2);
    send(32'h12345678, 2'd3);
    for (int i = 0; i < 10 && !(active && phase == 1); i++) tick();
    chk("clear_in_w1", 32'(active && phase == 1), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    chk("clear_valid", 32'(out_valid), 32'd0);
    chk("clear_busy",  32'(busy),      32'd0);
    drain(20);
    bad = 0;
    foreach (acc_q[k]) if (acc_q[k] == 32'hFFFF0000) bad++;
    chk("clear_no_w1", 32'(bad), 32'd0);
    chk("clear_words", 32'(acc_q.size()), 32'd1);

    // Two back-to-back frames: spacing and done pulses
    acc_q.delete();
    acc_t.delete();
    fd0 = fd_seen;
    out_ready = 1'b1;
    send(32'h01020304, 2'd1);
    send(32'hA0B0C0D0, 2'd3);
    drain(40);
    chk("gap_words", 32'(acc_t.size()), 32'd4);
    if (acc_t.size() == 4) chk("gap_cycles", 32'(acc_t[2] - acc_t[1] - 1), 32'(GAPW));
    chk("fd_pulses", 32'(fd_seen - fd0), 32'd2);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      req_valid  = ($urandom % 2) == 0;
      req_ip     = $urandom;
      req_offset = 2'($urandom_range(0, 3));
      out_ready  = ($urandom % 4) != 0;
      clear      = ($urandom % 50) == 0;
      tick();
    end
    drain(80);

    // Asynchronous reset mid-frame
    out_ready = 1'b0;
    send(32'hC0A80101, 2'd3);
    send(32'h0BADBEEF, 2'd0);
    tick();
    n_rst = 1'b0;
    #1;
    chk("rst_data",  data_out,          32'h0);
    chk("rst_valid", 32'(out_valid),    32'd0);
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_done",  32'(frame_done),   32'd0);
    model_reset();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    tick();
    chk("rst_ready", 32'(req_ready), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
